fsm_dispatcher: RTL
===================

Name: fsm_dispatcher

Overview:
- Parametrised control-unit dispatcher between the instruction decoder and N sub-FSMs (ALU, branch/jump, load/store, FP, ...).
- Accepts a one-hot start request and launches exactly one sub-FSM with a single-cycle pulse.
- Latches ownership for the whole instruction and routes the owner's packed control vector to the datapath; drives a fixed idle vector otherwise.
- Adds a watchdog against hung sub-FSMs and flags illegal multi-hot starts.

Parameters:
- N_FSM, 4, number of sub-FSM channels (>= 2).
- CTRL_W, 24, width of one packed control vector.
- IDLE_CTRL, 0, control vector driven when no channel owns the datapath.
- TIMEOUT_CYC, 255, watchdog limit in RUN cycles; 0 disables the watchdog.
- IDX_W, $clog2(N_FSM), width of active index.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  N_FSM  one-hot dispatch request from decoder (level, sampled in IDLE only).
- sub_ctrl  in  N_FSM*CTRL_W  packed sub-FSM control vectors; channel i occupies [i*CTRL_W +: CTRL_W].
- sub_done  in  N_FSM  per-channel done.
- fsm_start  out  N_FSM  one-cycle launch pulse to the selected sub-FSM, registered.
- ctrl  out  CTRL_W  datapath control vector.
- active  out  IDX_W  index of owning channel; 0 when idle.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle completion pulse to the top control unit, registered.
- timeout  out  1  one-cycle pulse, coincident with done, when completion was forced by the watchdog.
- err_multi  out  1  one-cycle pulse on a multi-hot start seen in IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, active=0, watchdog counter=0.
  - fsm_start, done, timeout, err_multi, busy all 0.
  - ctrl=IDLE_CTRL.
  - Reset mid-RUN abandons the instruction with no done pulse.
- States: IDLE, RUN, DRAIN.
- IDLE: ctrl=IDLE_CTRL, busy=0.
  - start==0: stay in IDLE.
  - Exactly one bit i set: latch active=i, counter=0, go to RUN. fsm_start[i]=1 during the first RUN cycle only.
  - More than one bit set: err_multi=1 next cycle, stay in IDLE, nothing launched.
- RUN: ctrl = sub_ctrl slice[active], selected combinationally from the latched index; busy=1.
  - Counter increments each cycle, saturating.
  - sub_done[active]=1, including in the first RUN cycle: go to DRAIN.
  - sub_done on any other channel: ignored.
  - TIMEOUT_CYC!=0 and counter reaches TIMEOUT_CYC-1 without done: go to DRAIN with the timeout flag set.
  - Done and timeout in the same cycle: done wins, timeout=0.
- DRAIN (exactly one cycle): ctrl=IDLE_CTRL, busy=1, done=1, timeout=flag; then IDLE with active cleared to 0.
- Latency:
  - start sampled at edge t: fsm_start and owner ctrl appear in cycle t+1.
  - sub_done at cycle t: done in cycle t+1, back in IDLE in cycle t+2.
  - Minimum 3 cycles per instruction.
  - A new start may be accepted in the first IDLE cycle after DRAIN.
- Start activity during RUN/DRAIN: ignored, no error; the decoder holds start until busy falls.
- All outputs except ctrl are registered; ctrl is a mux from registered state.

Test Plan (N_FSM=3, CTRL_W=8, IDLE_CTRL=8'h00, TIMEOUT_CYC=16):
- Reset: rst_n low mid-RUN with active=2 -> immediately ctrl=8'h00, busy=0, active=0, no done pulse; after release, IDLE.
- Normal dispatch: start=3'b010 at edge 0, sub_ctrl ch1=8'hA5, sub_done[1] at cycle 4 -> fsm_start=3'b010 in cycle 1 only, ctrl=8'hA5 in cycles 1-4, done=1 in cycle 5 with ctrl=8'h00, busy=0 in cycle 6.
- Immediate done: start=3'b100, sub_done[2]=1 in first RUN cycle -> done exactly 2 cycles after the start edge, timeout=0.
- Foreign done and ignored start: in RUN on ch0, assert sub_done[2] and start=3'b010 -> no done, ctrl stays ch0 vector, active=0.
- Watchdog: start=3'b001, sub_done held 0 -> DRAIN after 16 RUN cycles, done=1 and timeout=1 together; done+timeout in the same cycle -> timeout=0.
- Illegal start: start=3'b011 in IDLE -> err_multi pulse one cycle, fsm_start=0, busy=0; then start=3'b001 dispatches normally.

Source files
------------

// File: rtl/fsm_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : fsm_dispatcher
// Purpose  : Launches exactly one sub-FSM per instruction from a one-hot start,
//            holds ownership and routes the owner's control vector to the
//            datapath. A watchdog forces completion if a sub-FSM hangs.
// Revision : 1.0  initial release
// ============================================================================
module fsm_dispatcher #(
   parameter int unsigned           N_FSM       = 4,
   parameter int unsigned           CTRL_W      = 24,
   parameter logic [CTRL_W-1:0]     IDLE_CTRL   = '0,
   parameter int unsigned           TIMEOUT_CYC = 255,
   parameter int unsigned           IDX_W       = $clog2(N_FSM)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_FSM-1:0]          start_i,
   input  logic [N_FSM*CTRL_W-1:0]   sub_ctrl_i,
   input  logic [N_FSM-1:0]          sub_done_i,
   output logic [N_FSM-1:0]          fsm_start_o,
   output logic [CTRL_W-1:0]         ctrl_o,
   output logic [IDX_W-1:0]          active_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      timeout_o,
   output logic                      err_multi_o
);

   localparam logic [1:0] C_IDLE  = 2'd0;
   localparam logic [1:0] C_RUN   = 2'd1;
   localparam logic [1:0] C_DRAIN = 2'd2;

   localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [1:0]        state_q,     state_d;
   logic [IDX_W-1:0]  active_q,    active_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic [N_FSM-1:0]  fsm_start_q, fsm_start_d;
   logic              busy_q,      busy_d;
   logic              done_q,      done_d;
   logic              timeout_q,   timeout_d;
   logic              err_multi_q, err_multi_d;

   logic [CTRL_W-1:0] w_slice [N_FSM];
   logic              w_onehot;
   logic              w_multi;
   logic [IDX_W-1:0]  w_idx;
   logic              w_wd_hit;

   genvar gi;
   generate
      for (gi = 0; gi < N_FSM; gi++) begin : g_slice
         assign w_slice[gi] = sub_ctrl_i[gi*CTRL_W +: CTRL_W];
      end
   endgenerate

   // Counter sits at TIMEOUT_CYC-1 on the last RUN cycle the watchdog allows.
   generate
      if (TIMEOUT_CYC == 0) begin : g_wd_off
         assign w_wd_hit = 1'b0;
      end else begin : g_wd_on
         assign w_wd_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
      end
   endgenerate

   assign w_onehot = (start_i != '0) && ((start_i & (start_i - 1'b1)) == '0);
   assign w_multi  = (start_i != '0) && !w_onehot;

   always_comb begin
      w_idx = '0;
      for (int i = 0; i < N_FSM; i++) begin
         if (start_i[i]) w_idx = IDX_W'(i);
      end
   end

   always_comb begin
      state_d     = state_q;
      active_d    = active_q;
      cnt_d       = cnt_q;
      fsm_start_d = '0;
      done_d      = 1'b0;
      timeout_d   = 1'b0;
      err_multi_d = 1'b0;
      case (state_q)
         C_IDLE: begin
            if (w_onehot) begin
               state_d     = C_RUN;
               active_d    = w_idx;
               cnt_d       = '0;
               fsm_start_d = start_i;
            end else if (w_multi) begin
               err_multi_d = 1'b1;
            end
         end
         C_RUN: begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (sub_done_i[active_q]) begin
               state_d = C_DRAIN;
               done_d  = 1'b1;
            end else if (w_wd_hit) begin
               state_d   = C_DRAIN;
               done_d    = 1'b1;
               timeout_d = 1'b1;
            end
         end
         C_DRAIN: begin
            state_d  = C_IDLE;
            active_d = '0;
         end
         default: begin
            state_d  = C_IDLE;
            active_d = '0;
         end
      endcase
      busy_d = (state_d != C_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= C_IDLE;
         active_q    <= '0;
         cnt_q       <= '0;
         fsm_start_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         err_multi_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         active_q    <= active_d;
         cnt_q       <= cnt_d;
         fsm_start_q <= fsm_start_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
         err_multi_q <= err_multi_d;
      end
   end

   assign ctrl_o      = (state_q == C_RUN) ? w_slice[active_q] : IDLE_CTRL;
   assign fsm_start_o = fsm_start_q;
   assign active_o    = active_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign timeout_o   = timeout_q;
   assign err_multi_o = err_multi_q;

endmodule
`default_nettype wire
